// File: rtl/cpubus_pkg.sv
// Shared types and constants for the NORA CPU-bus initiator.
// FSM state encoding, reset address and phase-counter width.
package cpubus_pkg;

  localparam int CNT_W = 4;
  localparam logic [15:0] RST_ADDR = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQBUS,
    S_PHLO,
    S_PHHI,
    S_DONE
  } state_t;

endpackage

// File: rtl/cpubus_phase_timer.sv
// Loadable down-counter with zero flag; times both PHI2 phases.
// Saturates at zero so a stretched phase simply holds.
module cpubus_phase_timer
  import cpubus_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cpubus_initiator.sv
// 65xx-style bus initiator: PHI2-timed read/write cycles for ICD/DMA.
// Define CPUBUS_INITIATOR_RDY_EN to let bus_rdy_i stretch PHI2-high.
module cpubus_initiator
  import cpubus_pkg::*;
#(
  parameter int PHI_LO_CYC = 3,
  parameter int PHI_HI_CYC = 3,
  parameter int WDATA_DLY  = 1
) (
  input  logic        clk6x,
  input  logic        reset,
  input  logic        req_i,
  input  logic        req_rwn_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        ack_o,
  output logic [7:0]  rdata_o,
  output logic        busy_o,
  output logic        busreq_o,
  input  logic        busgnt_i,
  output logic        bus_phi2_o,
  output logic [15:0] bus_addr_o,
  output logic        bus_rwn_o,
  output logic        bus_drive_o,
  output logic [7:0]  bus_wdata_o,
  output logic        bus_wdata_oe_o,
  input  logic [7:0]  bus_rdata_i,
  input  logic        bus_rdy_i
);

  localparam logic [CNT_W-1:0] LO_LD = CNT_W'(PHI_LO_CYC - 1);
  localparam logic [CNT_W-1:0] HI_LD = CNT_W'(PHI_HI_CYC - 1);
  localparam logic [CNT_W-1:0] OE_AT = CNT_W'(PHI_HI_CYC - WDATA_DLY);

  state_t r_state, w_state;

  logic        r_lat_rwn, w_lat_rwn;
  logic [15:0] r_lat_addr, w_lat_addr;
  logic [7:0]  r_lat_wdata, w_lat_wdata;

  logic        r_ack, w_ack;
  logic [7:0]  r_rdata, w_rdata;
  logic        r_busy, w_busy;
  logic        r_busreq, w_busreq;
  logic        r_phi2, w_phi2;
  logic [15:0] r_addr, w_addr;
  logic        r_rwn, w_rwn;
  logic        r_drive, w_drive;
  logic [7:0]  r_wdata, w_wdata;
  logic        r_oe, w_oe;

  logic             w_load;
  logic             w_dec;
  logic [CNT_W-1:0] w_ld_val;
  logic [CNT_W-1:0] w_cnt;
  logic             w_zero;
  logic             w_rdy;

`ifdef CPUBUS_INITIATOR_RDY_EN
  assign w_rdy = bus_rdy_i;
`else
  assign w_rdy = bus_rdy_i | 1'b1;
`endif

  cpubus_phase_timer u_timer (
    .i_clk  (clk6x),
    .i_rst  (reset),
    .i_load (w_load),
    .i_val  (w_ld_val),
    .i_dec  (w_dec),
    .o_cnt  (w_cnt),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lat_rwn   <= 1'b1;
      r_lat_addr  <= RST_ADDR;
      r_lat_wdata <= '0;
      r_ack       <= 1'b0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_busreq    <= 1'b0;
      r_phi2      <= 1'b0;
      r_addr      <= RST_ADDR;
      r_rwn       <= 1'b1;
      r_drive     <= 1'b0;
      r_wdata     <= '0;
      r_oe        <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_lat_rwn   <= w_lat_rwn;
      r_lat_addr  <= w_lat_addr;
      r_lat_wdata <= w_lat_wdata;
      r_ack       <= w_ack;
      r_rdata     <= w_rdata;
      r_busy      <= w_busy;
      r_busreq    <= w_busreq;
      r_phi2      <= w_phi2;
      r_addr      <= w_addr;
      r_rwn       <= w_rwn;
      r_drive     <= w_drive;
      r_wdata     <= w_wdata;
      r_oe        <= w_oe;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_lat_rwn   = r_lat_rwn;
    w_lat_addr  = r_lat_addr;
    w_lat_wdata = r_lat_wdata;
    w_ack       = 1'b0;
    w_rdata     = r_rdata;
    w_busy      = r_busy;
    w_busreq    = r_busreq;
    w_phi2      = r_phi2;
    w_addr      = r_addr;
    w_rwn       = r_rwn;
    w_drive     = r_drive;
    w_wdata     = r_wdata;
    w_oe        = r_oe;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_ld_val    = LO_LD;
    unique case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_lat_rwn   = req_rwn_i;
          w_lat_addr  = req_addr_i;
          w_lat_wdata = req_wdata_i;
          w_busreq    = 1'b1;
          w_busy      = 1'b1;
          w_state     = S_REQBUS;
        end
      end
      S_REQBUS: begin
        if (busgnt_i) begin
          w_drive  = 1'b1;
          w_addr   = r_lat_addr;
          w_rwn    = r_lat_rwn;
          w_wdata  = r_lat_wdata;
          w_phi2   = 1'b0;
          w_load   = 1'b1;
          w_ld_val = LO_LD;
          w_state  = S_PHLO;
        end
      end
      S_PHLO: begin
        if (w_zero) begin
          w_phi2   = 1'b1;
          w_load   = 1'b1;
          w_ld_val = HI_LD;
          w_state  = S_PHHI;
          if (!r_rwn && (WDATA_DLY == 0)) w_oe = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      S_PHHI: begin
        w_dec = 1'b1;
        if (!r_rwn && (w_cnt == OE_AT)) w_oe = 1'b1;
        // with RDY low the timer sits at zero, stretching PHI2-high
        if (w_zero && w_rdy) begin
          if (r_rwn) w_rdata = bus_rdata_i;
          w_phi2  = 1'b0;
          w_ack   = 1'b1;
          w_state = S_DONE;
        end
      end
      S_DONE: begin
        w_oe = 1'b0;
        if (req_i && busgnt_i) begin
          w_lat_rwn   = req_rwn_i;
          w_lat_addr  = req_addr_i;
          w_lat_wdata = req_wdata_i;
          w_addr      = req_addr_i;
          w_rwn       = req_rwn_i;
          w_wdata     = req_wdata_i;
          w_load      = 1'b1;
          w_ld_val    = LO_LD;
          w_state     = S_PHLO;
        end else begin
          w_busreq = 1'b0;
          w_drive  = 1'b0;
          w_busy   = 1'b0;
          w_rwn    = 1'b1;
          w_state  = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign ack_o          = r_ack;
  assign rdata_o        = r_rdata;
  assign busy_o         = r_busy;
  assign busreq_o       = r_busreq;
  assign bus_phi2_o     = r_phi2;
  assign bus_addr_o     = r_addr;
  assign bus_rwn_o      = r_rwn;
  assign bus_drive_o    = r_drive;
  assign bus_wdata_o    = r_wdata;
  assign bus_wdata_oe_o = r_oe;

endmodule

// File: doc/cpubus_initiator.md
Name: cpubus_initiator

Overview:
- Synthesizable 65xx-style bus initiator inside NORA.
- Generates PHI2-timed read/write cycles on the CPU/memory bus on behalf of an internal client (ICD debugger, DMA).
- It is the master-side counterpart of NORA's CPU-bus responder logic: it requests the bus while the CPU is held off (CBE low), then drives address, R/Wn, data and PHI2.
- Returns read data, or a write acknowledge, through a req/ack handshake.

Parameters:
- PHI_LO_CYC, 3, clk6x cycles PHI2 is low per bus cycle (address setup phase); legal range 2..15.
- PHI_HI_CYC, 3, clk6x cycles PHI2 is high per bus cycle (data phase); legal range 2..15.
- WDATA_DLY, 1, clk6x cycles after PHI2 rise before write data output-enable asserts; must be < PHI_HI_CYC.

Ports:
- clk6x  in  1  system clock (6x CPU clock domain)
- reset  in  1  asynchronous reset, active high
- req_i  in  1  client request; held high with stable fields until ack_o
- req_rwn_i  in  1  1=read, 0=write
- req_addr_i  in  16  bus address
- req_wdata_i  in  8  write data
- ack_o  out  1  one-cycle pulse: transaction complete
- rdata_o  out  8  read data; valid from ack_o onwards, held until next ack
- busy_o  out  1  high from bus request until return to IDLE
- busreq_o  out  1  request ownership of bus (CPU to be stopped, CBE low)
- busgnt_i  in  1  ownership granted (synchronous to clk6x)
- bus_phi2_o  out  1  PHI2 while owner
- bus_addr_o  out  16  address
- bus_rwn_o  out  1  R/Wn
- bus_drive_o  out  1  output-enable for addr/rwn/phi2
- bus_wdata_o  out  8  write data
- bus_wdata_oe_o  out  1  output-enable for data bus
- bus_rdata_i  in  8  data bus input
- bus_rdy_i  in  1  wait-state input (used only with the optional feature)

Behaviour:
- Reset values: ack_o=0, rdata_o=0, busy_o=0, busreq_o=0, bus_phi2_o=0, bus_addr_o=0xFFFF, bus_rwn_o=1, bus_drive_o=0, bus_wdata_o=0, bus_wdata_oe_o=0.
- All outputs are registered.
- FSM states: IDLE, REQBUS, PHLO, PHHI, DONE. A 4-bit phase counter cnt reloads on every phase entry.
- IDLE: on req_i=1, latch addr/rwn/wdata, set busreq_o=1 and busy_o=1, go to REQBUS.
- REQBUS: wait for busgnt_i=1; then bus_drive_o=1, drive latched addr and rwn, phi2=0, cnt=PHI_LO_CYC-1, go to PHLO. No timeout.
- PHLO: phi2=0; decrement cnt; at cnt=0 set phi2=1, cnt=PHI_HI_CYC-1, go to PHHI.
- PHHI: phi2=1. For writes, bus_wdata_oe_o rises WDATA_DLY cycles after PHI2 rise. At cnt=0:
  - read: sample bus_rdata_i into rdata_o;
  - write: keep wdata driven;
  - set phi2=0, go to DONE.
- DONE (1 cycle): ack_o=1.
  - Address, rwn and write data are held one cycle past PHI2 fall (hold time); bus_wdata_oe_o deasserts at exit of DONE.
  - If req_i is still high, treat it as the next back-to-back transaction: relatch fields and go directly to PHLO with busreq_o kept high. The client must drop or refresh req_i in the cycle after ack.
  - Otherwise deassert busreq_o, bus_drive_o and busy_o, set rwn=1, go to IDLE.
- Bus cycle length is PHI_LO_CYC+PHI_HI_CYC clocks. First-transaction latency from req_i to ack_o is 1 + grant wait + PHI_LO_CYC + PHI_HI_CYC + 1 clocks.
- busgnt_i dropping mid-cycle is ignored until DONE. At DONE, if the grant is gone, go to IDLE even if req_i is high, and re-arbitrate.
- req_i dropping before ack_o is a protocol violation; the cycle still completes and ack_o still pulses.
- Asynchronous reset mid-cycle immediately releases the bus (drive/oe=0) and discards the transaction; no ack is issued.

Optional Feature:
- Macro CPUBUS_INITIATOR_RDY_EN.
- When defined: in PHHI at cnt=0, if bus_rdy_i=0, hold phi2=1 and cnt=0 (wait state) until bus_rdy_i=1, then sample and proceed. No limit on stretch length.
- When undefined: bus_rdy_i is ignored and the cycle length is fixed.

Decomposition:
- Package cpubus_pkg: FSM state enum, reset address constant 16'hFFFF, phase-counter width constant (4).
- One natural sub-module: cpubus_phase_timer, a loadable down-counter with zero flag, shared by PHLO and PHHI.
- Everything else stays in the top.

Test Plan:
- Read 0x0010 with SRAM model holding 0x12, busgnt_i tied 1 -> ack_o 8 clocks after req_i, rdata_o=0x12, bus_rwn_o=1 throughout, bus_wdata_oe_o never set.
- Write 0xAB to 0x9F02 -> bus_addr_o=0x9F02 and bus_rwn_o=0 during the whole cycle; bus_wdata_oe_o high from PHI2-rise+1 through DONE; SRAM/VIA model captures 0xAB on PHI2 fall.
- Four back-to-back writes 0x12/0x34/0x56/0x78 to 0x0010..0x0013, then four reads -> busreq_o never drops between transactions, and the reads return 0x12, 0x34, 0x56, 0x78.
- busgnt_i delayed 10 clocks -> bus_drive_o stays 0 and phi2 stays 0 until grant; ack_o arrives at 18 clocks.
- With CPUBUS_INITIATOR_RDY_EN, bus_rdy_i=0 for 5 clocks at end of PHHI -> PHI2 high phase stretched by exactly 5; rdata_o sampled after RDY returns high.
- Assert reset during PHHI of a write -> bus_drive_o=0, bus_wdata_oe_o=0, busreq_o=0 immediately; no ack_o; next request completes normally.
